// File: rtl/input_line_packer.sv
// rtl/input_line_packer.sv - packs pixel samples into 72-bit lines and sequences a block of lines
module input_line_packer #(
   parameter int PIXEL_W         = 8,
   parameter int PIXELS_PER_LINE = 9,
   parameter int LINES_PER_BLOCK = 15
) (
   input  logic                               CLK,
   input  logic                               RST_ASYNC,
   input  logic                               START,
   input  logic                               HOLD,
   input  logic                               PIX_VALID,
   input  logic [PIXEL_W-1:0]                 PIX_IN,
   output logic                               PIX_READY,
   output logic                               LINE_WRITE_EN,
   output logic [PIXEL_W*PIXELS_PER_LINE-1:0] LINE_DATA,
   output logic [3:0]                         LINE_IDX,
   output logic                               BUSY,
   output logic                               BLOCK_DONE
);

   localparam int LINE_W = PIXEL_W * PIXELS_PER_LINE;

   typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

   state_t     state;
   logic [3:0] pix_cnt;

   assign PIX_READY     = (state == FILL);
   assign LINE_WRITE_EN = (state == EMIT) && !HOLD;

   always_ff @(posedge CLK or posedge RST_ASYNC) begin
      if (RST_ASYNC) begin
         state      <= IDLE;
         pix_cnt    <= 4'd0;
         LINE_DATA  <= '0;
         LINE_IDX   <= 4'd0;
         BUSY       <= 1'b0;
         BLOCK_DONE <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (START) begin
                  pix_cnt  <= 4'd0;
                  LINE_IDX <= 4'd0;
                  BUSY     <= 1'b1;
                  state    <= FILL;
               end
            end
            FILL: begin
               // Shifting left means the oldest sample ends up in the top byte.
               if (PIX_VALID) begin
                  LINE_DATA <= {LINE_DATA[LINE_W-PIXEL_W-1:0], PIX_IN};
                  if (pix_cnt == 4'(PIXELS_PER_LINE - 1)) begin
                     pix_cnt <= 4'd0;
                     state   <= EMIT;
                  end else begin
                     pix_cnt <= pix_cnt + 4'd1;
                  end
               end
            end
            EMIT: begin
               if (!HOLD) begin
                  if (LINE_IDX == 4'(LINES_PER_BLOCK - 1)) begin
                     BLOCK_DONE <= 1'b1;
                     state      <= DONE;
                  end else begin
                     LINE_IDX <= LINE_IDX + 4'd1;
                     state    <= FILL;
                  end
               end
            end
            DONE: begin
               BLOCK_DONE <= 1'b0;
               BUSY       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_input_line_packer.sv
// tb/tb_input_line_packer.sv - directed self-checking bench for input_line_packer
module tb_input_line_packer;

   logic        CLK = 1'b0;
   logic        RST_ASYNC = 1'b1;
   logic        START = 1'b0;
   logic        HOLD = 1'b0;
   logic        PIX_VALID = 1'b0;
   logic [7:0]  PIX_IN = 8'd0;
   logic        PIX_READY;
   logic        LINE_WRITE_EN;
   logic [71:0] LINE_DATA;
   logic [3:0]  LINE_IDX;
   logic        BUSY;
   logic        BLOCK_DONE;

   int vectors = 0;
   int miscompares = 0;

   input_line_packer dut (
      .CLK(CLK), .RST_ASYNC(RST_ASYNC), .START(START), .HOLD(HOLD),
      .PIX_VALID(PIX_VALID), .PIX_IN(PIX_IN), .PIX_READY(PIX_READY),
      .LINE_WRITE_EN(LINE_WRITE_EN), .LINE_DATA(LINE_DATA), .LINE_IDX(LINE_IDX),
      .BUSY(BUSY), .BLOCK_DONE(BLOCK_DONE)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      chk(tag, {71'd0, obs}, {71'd0, exp});
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      chk(tag, {68'd0, obs}, {68'd0, exp});
   endtask

   function automatic logic [71:0] pack(input logic [7:0] base);
      logic [71:0] d = '0;
      for (int i = 0; i < 9; i++) d = {d[63:0], 8'(base + 8'(i))};
      return d;
   endfunction

   // Sends n samples base, base+1, ...; optional idle cycle before each sample after the first.
   task automatic feed(input logic [7:0] base, input int n, input bit bubbles);
      for (int i = 0; i < n; i++) begin
         if (bubbles && i > 0) begin
            PIX_VALID = 1'b0;
            PIX_IN    = 8'hFF;
            #1;
            chk1("gap_ready", PIX_READY, 1'b1);
            tick();
         end
         PIX_VALID = 1'b1;
         PIX_IN    = 8'(base + 8'(i));
         #1;
         chk1("fill_ready", PIX_READY, 1'b1);
         chk1("fill_we", LINE_WRITE_EN, 1'b0);
         tick();
      end
      PIX_VALID = 1'b0;
      PIX_IN    = 8'd0;
   endtask

   task automatic expect_emit(input logic [71:0] data, input logic [3:0] idx);
      chk1("emit_we", LINE_WRITE_EN, 1'b1);
      chk1("emit_ready", PIX_READY, 1'b0);
      chk("emit_data", LINE_DATA, data);
      chk4("emit_idx", LINE_IDX, idx);
   endtask

   task automatic start_block();
      START = 1'b1;
      tick();
      START = 1'b0;
      chk1("start_busy", BUSY, 1'b1);
      chk1("start_ready", PIX_READY, 1'b1);
      chk4("start_idx", LINE_IDX, 4'd0);
   endtask

   initial begin
      // reset held through two edges
      tick();
      tick();
      chk("rst_data", LINE_DATA, 72'd0);
      chk4("rst_idx", LINE_IDX, 4'd0);
      chk1("rst_busy", BUSY, 1'b0);
      chk1("rst_done", BLOCK_DONE, 1'b0);
      chk1("rst_ready", PIX_READY, 1'b0);
      chk1("rst_we", LINE_WRITE_EN, 1'b0);
      RST_ASYNC = 1'b0;
      tick();
      chk1("idle_busy", BUSY, 1'b0);
      chk1("idle_ready", PIX_READY, 1'b0);

      // asynchronous reset between edges clears a partly filled line
      start_block();
      feed(8'h55, 3, 1'b0);
      chk1("part_busy", BUSY, 1'b1);
      #2;
      RST_ASYNC = 1'b1;
      #1;
      chk("arst_data", LINE_DATA, 72'd0);
      chk1("arst_busy", BUSY, 1'b0);
      chk1("arst_ready", PIX_READY, 1'b0);
      chk1("arst_we", LINE_WRITE_EN, 1'b0);
      chk4("arst_idx", LINE_IDX, 4'd0);
      chk1("arst_done", BLOCK_DONE, 1'b0);
      tick();
      RST_ASYNC = 1'b0;
      tick();

      // line 0: back-to-back samples
      start_block();
      feed(8'h01, 9, 1'b0);
      expect_emit(72'h010203040506070809, 4'd0);
      tick();
      chk1("l1_ready", PIX_READY, 1'b1);
      chk1("l1_we", LINE_WRITE_EN, 1'b0);
      chk4("l1_idx", LINE_IDX, 4'd1);

      // line 1: bubbles on alternate cycles carry junk that must be ignored
      feed(8'hA0, 9, 1'b1);
      expect_emit(72'hA0A1A2A3A4A5A6A7A8, 4'd1);
      tick();
      chk4("l2_idx", LINE_IDX, 4'd2);

      // line 2: HOLD raised during FILL, kept for 3 cycles of EMIT
      HOLD = 1'b1;
      feed(8'h20, 9, 1'b0);
      for (int c = 0; c < 3; c++) begin
         chk1("hold_we", LINE_WRITE_EN, 1'b0);
         chk1("hold_ready", PIX_READY, 1'b0);
         chk("hold_data", LINE_DATA, 72'h202122232425262728);
         chk4("hold_idx", LINE_IDX, 4'd2);
         tick();
      end
      HOLD = 1'b0;
      #1;
      expect_emit(72'h202122232425262728, 4'd2);
      tick();
      chk4("l3_idx", LINE_IDX, 4'd3);

      // lines 3..14, START re-pulsed mid-block, START also raised in DONE
      for (int l = 3; l < 15; l++) begin
         if (l == 7) begin
            START = 1'b1;
            tick();
            START = 1'b0;
            chk4("restart_idx", LINE_IDX, 4'd7);
            chk1("restart_busy", BUSY, 1'b1);
         end
         feed(8'(l * 16), 9, l[0]);
         expect_emit(pack(8'(l * 16)), 4'(l));
         tick();
         if (l < 14) begin
            chk4("next_idx", LINE_IDX, 4'(l + 1));
            chk1("next_done", BLOCK_DONE, 1'b0);
         end
      end
      chk1("done_pulse", BLOCK_DONE, 1'b1);
      chk1("done_busy", BUSY, 1'b1);
      chk1("done_we", LINE_WRITE_EN, 1'b0);
      chk4("done_idx", LINE_IDX, 4'd14);
      START = 1'b1;
      tick();
      START = 1'b0;
      chk1("post_done", BLOCK_DONE, 1'b0);
      chk1("post_busy", BUSY, 1'b0);
      chk1("post_ready", PIX_READY, 1'b0);
      chk4("post_idx", LINE_IDX, 4'd14);
      tick();
      chk1("idle2_busy", BUSY, 1'b0);

      // reset after 5 samples of line 3, then a fresh block
      start_block();
      for (int l = 0; l < 3; l++) begin
         feed(8'(8'h40 + l * 16), 9, 1'b0);
         expect_emit(pack(8'(8'h40 + l * 16)), 4'(l));
         tick();
      end
      feed(8'h77, 5, 1'b0);
      chk4("mid_idx", LINE_IDX, 4'd3);
      #2;
      RST_ASYNC = 1'b1;
      #1;
      chk4("mid_rst_idx", LINE_IDX, 4'd0);
      chk1("mid_rst_busy", BUSY, 1'b0);
      tick();
      RST_ASYNC = 1'b0;
      tick();
      start_block();
      feed(8'h11, 9, 1'b0);
      expect_emit(72'h111213141516171819, 4'd0);
      tick();
      chk4("final_idx", LINE_IDX, 4'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
